// File: rtl/arctan_pkg.sv
// Shared widths, arctangent table and FSM encoding for the iterative arctan engine.
package arctan_pkg;

  localparam int unsigned IN_W     = 32;
  localparam int unsigned OUT_W    = 32;
  localparam int unsigned XY_W     = 35;
  localparam int unsigned Z_W      = 42;
  localparam int unsigned OUT_FRAC = 16;
  localparam int unsigned ATAN_W   = 40;
  localparam int unsigned ATAN_N   = 38;
  localparam int unsigned IDX_W    = 6;

  // +90 degrees in the Q10.32 angle accumulator format
  localparam logic signed [Z_W-1:0] DEG90 = Z_W'(64'd90 << 32);

  // round(atan(2^-i) * 2^32), degrees, Q8.32
  localparam logic [ATAN_W-1:0] ATAN [0:ATAN_N-1] = '{
    40'd193273528320, 40'd114096026022, 40'd60285206653,  40'd30601712202,
    40'd15360239180,  40'd7687607525,   40'd3844741810,   40'd1922488225,
    40'd961258780,    40'd480631223,    40'd240315841,    40'd120157949,
    40'd60078978,     40'd30039490,     40'd15019745,     40'd7509872,
    40'd3754936,      40'd1877468,      40'd938734,       40'd469367,
    40'd234684,       40'd117342,       40'd58671,        40'd29335,
    40'd14668,        40'd7334,         40'd3667,         40'd1833,
    40'd917,          40'd458,          40'd229,          40'd115,
    40'd57,           40'd29,           40'd14,           40'd7,
    40'd4,            40'd2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ROT  = 2'd2
  } state_e;

endpackage

// File: rtl/arctan_stage.sv
// One CORDIC vectoring micro-rotation: drives y toward zero, accumulating angle in z.
module arctan_stage
  import arctan_pkg::*;
(
  input  logic signed [XY_W-1:0]   x_i,
  input  logic signed [XY_W-1:0]   y_i,
  input  logic signed [Z_W-1:0]    z_i,
  input  logic        [IDX_W-1:0]  i_i,
  input  logic        [ATAN_W-1:0] atan_i,
  output logic signed [XY_W-1:0]   x_o,
  output logic signed [XY_W-1:0]   y_o,
  output logic signed [Z_W-1:0]    z_o
);

  logic signed [XY_W-1:0] x_sh;
  logic signed [XY_W-1:0] y_sh;
  logic signed [Z_W-1:0]  atan_z;

  // Rotate by -/+ atan(2^-i) depending on the sign of y; shifts use pre-update values
  always_comb begin
    x_sh   = x_i >>> i_i;
    y_sh   = y_i >>> i_i;
    atan_z = Z_W'(atan_i);
    if (!y_i[XY_W-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_z;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_z;
    end
  end

endmodule

// File: rtl/arctan_seq.sv
// Sequential atan2(y, x) in Q16.16 degrees using a single reused CORDIC stage.
module arctan_seq
  import arctan_pkg::*;
#(
  parameter int unsigned ITER = 32
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [IN_W-1:0]  inx,
  input  logic signed [IN_W-1:0]  iny,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] out
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       i_q, i_d;
  logic signed [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [Z_W-1:0]  z_q, z_d;
  logic                   zero_q, zero_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic signed [OUT_W-1:0] out_q, out_d;

  logic signed [XY_W-1:0] x_nxt, y_nxt;
  logic signed [Z_W-1:0]  z_nxt;

  arctan_stage u_stage (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .i_i    (i_q),
    .atan_i (ATAN[i_q]),
    .x_o    (x_nxt),
    .y_o    (y_nxt),
    .z_o    (z_nxt)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  // Next-state: capture, quadrant pre-rotation, then ITER micro-rotations
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = XY_W'(inx);
          y_d     = XY_W'(iny);
          busy_d  = 1'b1;
          state_d = PRE;
        end
      end
      PRE: begin
        // Fold the left half-plane into the CORDIC convergence range
        zero_d = (x_q == '0) && (y_q == '0);
        if (x_q[XY_W-1] && !y_q[XY_W-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = DEG90;
        end else if (x_q[XY_W-1] && y_q[XY_W-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -DEG90;
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        state_d = ROT;
      end
      ROT: begin
        x_d = x_nxt;
        y_d = y_nxt;
        z_d = z_nxt;
        i_d = i_q + IDX_W'(1);
        if (i_q == IDX_W'(ITER - 1)) begin
          out_d   = zero_q ? '0 : OUT_W'(z_nxt >>> OUT_FRAC);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          i_d     = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_arctan_seq.sv
// Directed bench for arctan_seq: latency, angles per quadrant, extremes, handshake, reset abort.
module tb_arctan_seq;

  localparam int unsigned ITER = 32;
  localparam int LAT = ITER + 2;

  // Q16.16 degree constants
  localparam int D0    = 0;
  localparam int D45   = 2949120;    // 0x002D0000
  localparam int D90   = 5898240;    // 0x005A0000
  localparam int D180  = 11796480;   // 0x00B40000
  localparam int DM45  = -2949120;   // 0xFFD30000
  localparam int DM135 = -8847360;   // 0xFF790000
  localparam int D26   = 1740967;    // atan(0.5)  = 26.5650512 deg
  localparam int D153  = 10055513;   // 180 - 26.5650512 deg

  // Integer x/y bound the achievable angle resolution to roughly ITER/|v| radians
  localparam int TOL_FINE = 2;
  localparam int TOL_64K  = 8192;    // |v| ~ 2^16 : 0.125 deg
  localparam int TOL_1K   = 262144;  // |v| ~ 1000 : 4 deg

  localparam logic signed [31:0] P30 = 32'sh40000000;
  localparam logic signed [31:0] P29 = 32'sh20000000;
  localparam logic signed [31:0] N30 = -32'sh40000000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [31:0] inx;
  logic signed [31:0] iny;
  logic busy;
  logic done;
  logic signed [31:0] out_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arctan_seq #(.ITER(ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inx   (inx),
    .iny   (iny),
    .busy  (busy),
    .done  (done),
    .out   (out_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [31:0] obs,
                            input int exp, input int tol);
    longint d;
    logic   ok;
    d = longint'(obs) - longint'(exp);
    if (d < 0) d = -d;
    ok = (d <= longint'(tol));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Issue one request, scramble operands while busy, wait (bounded) for done
  task automatic run_op(input logic signed [31:0] x, input logic signed [31:0] y,
                        input string tag, output logic signed [31:0] res, output int lat);
    inx   = x;
    iny   = y;
    start = 1'b1;
    step();
    start = 1'b0;
    inx   = 32'sh5A5A5A5A;
    iny   = -32'sd12345;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < LAT + 20) begin
      step();
      lat++;
    end
    res = out_s;
  endtask

  task automatic op(input string tag, input logic signed [31:0] x, input logic signed [31:0] y,
                    input int exp, input int tol);
    logic signed [31:0] res;
    int lat;
    run_op(x, y, tag, res, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
    check_near(tag, res, exp, tol);
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    step();
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_near({tag, "_hold"}, out_s, exp, tol);
  endtask

  initial begin
    int ndone;
    int last;
    int lat;

    rst   = 1'b1;
    start = 1'b0;
    inx   = '0;
    iny   = '0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_out",  out_s,     32'd0);
    end

    // Principal angles and quadrant pre-rotation, small operands
    op("p45_64k",  32'sd65536, 32'sd65536, D45,   TOL_64K);
    op("p0_1k",    32'sd1000,  32'sd0,     D0,    TOL_1K);
    op("p90_1k",   32'sd0,     32'sd1000,  D90,   TOL_1K);
    op("q180_1k", -32'sd1000,  32'sd0,     D180,  TOL_1K);
    op("qm135_1k",-32'sd1000, -32'sd1000,  DM135, TOL_1K);
    op("qm45_1k",  32'sd1000, -32'sd1000,  DM45,  TOL_1K);

    // Same directions with large operands, where the datapath resolves to LSBs
    op("p45",    P30, P30, D45,   TOL_FINE);
    op("p0",     P30, '0,  D0,    TOL_FINE);
    op("p90",    '0,  P30, D90,   TOL_FINE);
    op("q180",   N30, '0,  D180,  TOL_FINE);
    op("qm135",  N30, N30, DM135, TOL_FINE);
    op("qm45",   P30, N30, DM45,  TOL_FINE);
    op("p26",    P30, P29, D26,   TOL_FINE);
    op("q153",   N30, P29, D153,  TOL_FINE);

    // Extremes
    op("xmin_180", 32'sh80000000, 32'sh00000000, D180, TOL_FINE);
    op("xmax_ymin", 32'sh7FFFFFFF, 32'sh80000000, DM45, TOL_FINE);
    op("zero", 32'sd0, 32'sd0, D0, 0);

    // start held high for 100 cycles: back-to-back results every LAT cycles
    inx   = P30;
    iny   = P29;
    start = 1'b1;
    ndone = 0;
    last  = 0;
    for (int c = 1; c <= 110; c++) begin
      if (c == 101) start = 1'b0;
      step();
      if (done === 1'b1) begin
        ndone++;
        check_eq("b2b_gap", 32'(c - last), 32'(LAT));
        check_near("b2b_out", out_s, D26, TOL_FINE);
        last = c;
      end
    end
    check_eq("b2b_count", 32'(ndone), 32'd3);

    // start pulse while busy is ignored along with its operands
    inx   = P30;
    iny   = P30;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    repeat (5) begin
      step();
      lat++;
    end
    inx   = N30;
    iny   = 32'sd0;
    start = 1'b1;
    step();
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < LAT + 20) begin
      step();
      lat++;
    end
    check_eq("ign_lat", 32'(lat), 32'(LAT));
    check_near("ign_out", out_s, D45, TOL_FINE);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check_eq("ign_no_extra_done", 32'(ndone), 32'd0);

    // Reset at cycle 10 of an operation aborts it
    inx   = N30;
    iny   = 32'sd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_out",  out_s,     32'd0);
    step();
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check_eq("abort_no_done", 32'(ndone), 32'd0);
    check_eq("abort_out_stays", out_s, 32'd0);
    op("after_abort", P30, P29, D26, TOL_FINE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
